// File: rtl/keypad_scan_entry.sv
// 4x4 active-low matrix keypad scanner with debounce; accepted keys shift
// into a 32-bit hex entry register that can feed the 7-segment display driver.
module keypad_scan_entry #(
    parameter int SCAN_DIV       = 17,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [31:0] x,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_down
);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    localparam logic [3:0] DEB_N = 4'(DEBOUNCE_SCANS);

    state_t              state, state_nx;
    logic [SCAN_DIV-1:0] presc;
    logic [3:0]          col_m, col_s;
    logic [1:0]          row_idx, hold_row, hold_col, col_idx;
    logic [3:0]          deb_cnt, deb_nx, acc_code;
    logic                tick, pressed, hold_hit;
    logic                row_adv, latch, accept, release_k;

    assign tick     = &presc;
    assign pressed  = (col_s != 4'b1111);
    assign hold_hit = ~col_s[hold_col];

    always_comb begin
        if (!col_s[0])      col_idx = 2'd0;
        else if (!col_s[1]) col_idx = 2'd1;
        else if (!col_s[2]) col_idx = 2'd2;
        else                col_idx = 2'd3;
    end

    // Accepting straight from SCAN (single-scan debounce) uses the live indices.
    assign acc_code = (state == SCAN) ? {row_idx, col_idx} : {hold_row, hold_col};

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= SCAN;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        deb_nx    = deb_cnt;
        row_adv   = 1'b0;
        latch     = 1'b0;
        accept    = 1'b0;
        release_k = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (!pressed) begin
                        row_adv = 1'b1;
                    end else begin
                        latch = 1'b1;
                        if (DEB_N == 4'd1) begin
                            accept   = 1'b1;
                            deb_nx   = '0;
                            state_nx = HELD;
                        end else begin
                            deb_nx   = 4'd1;
                            state_nx = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (hold_hit) begin
                        if (deb_cnt + 4'd1 == DEB_N) begin
                            accept   = 1'b1;
                            deb_nx   = '0;
                            state_nx = HELD;
                        end else begin
                            deb_nx = deb_cnt + 4'd1;
                        end
                    end else begin
                        deb_nx   = '0;
                        row_adv  = 1'b1;
                        state_nx = SCAN;
                    end
                end
                HELD: begin
                    if (!hold_hit) begin
                        if (deb_cnt + 4'd1 == DEB_N) begin
                            release_k = 1'b1;
                            deb_nx    = '0;
                            row_adv   = 1'b1;
                            state_nx  = SCAN;
                        end else begin
                            deb_nx = deb_cnt + 4'd1;
                        end
                    end else begin
                        deb_nx = '0;
                    end
                end
                default: state_nx = SCAN;
            endcase
        end
    end

    always_comb begin
        row = ~(4'b0001 << row_idx);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            presc     <= '0;
            col_m     <= '1;
            col_s     <= '1;
            row_idx   <= '0;
            hold_row  <= '0;
            hold_col  <= '0;
            deb_cnt   <= '0;
            x         <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            presc     <= presc + 1'b1;
            col_m     <= col;
            col_s     <= col_m;
            deb_cnt   <= deb_nx;
            key_valid <= accept;
            if (row_adv) row_idx <= row_idx + 2'd1;
            if (latch) begin
                hold_row <= row_idx;
                hold_col <= col_idx;
            end
            if (accept) begin
                key_code <= acc_code;
                x        <= {x[27:0], acc_code};
                key_down <= 1'b1;
            end
            if (release_k) key_down <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scan_entry.sv
// Directed bench for keypad_scan_entry: a keypad matrix model drives col from
// row, and a scoreboard checks every key_valid pulse against queued expectations.
module tb_keypad_scan_entry;

    logic        clk, clr;
    logic [3:0]  col, row, key_code;
    logic [31:0] x;
    logic        key_valid, key_down;

    logic [15:0] keys;
    logic [31:0] exp_x;
    logic        prev_kv;
    int          n_assert, n_fail;

    typedef struct packed {
        logic [3:0]  code;
        logic [31:0] xv;
    } exp_t;
    exp_t sb[$];

    keypad_scan_entry #(.SCAN_DIV(2), .DEBOUNCE_SCANS(4)) dut (
        .clk(clk), .clr(clr), .col(col), .row(row), .x(x),
        .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // A held key (bit index = {row,col}) pulls its column low while its row is driven.
    always_comb begin
        col = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_key(input logic [3:0] code);
        exp_x = {exp_x[27:0], code};
        sb.push_back('{code: code, xv: exp_x});
    endtask

    task automatic press(input logic [3:0] code);
        expect_key(code);
        keys = '0;
        keys[code] = 1'b1;
        cyc(40);
        chk("key_down_held", {31'b0, key_down}, 1);
        keys = '0;
        cyc(28);
        chk("key_down_released", {31'b0, key_down}, 0);
    endtask

    // Returns on the first negedge after row newly takes value v (i.e. just after a tick).
    task automatic wait_row(input logic [3:0] v);
        int i;
        i = 0;
        while (row === v && i < 40) begin @(negedge clk); i++; end
        i = 0;
        while (row !== v && i < 40) begin @(negedge clk); i++; end
        chk("wait_row", {28'b0, row}, {28'b0, v});
    endtask

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            chk("kv_not_back_to_back", {31'b0, prev_kv}, 0);
            chk("pulse_expected", {31'b0, sb.size() != 0}, 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("key_code", {28'b0, key_code}, {28'b0, e.code});
                chk("x_at_pulse", x, e.xv);
                chk("key_down_at_pulse", {31'b0, key_down}, 1);
            end
        end
        prev_kv = key_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;
        prev_kv  = 1'b0;
        keys     = '0;
        exp_x    = '0;
        clr      = 1'b1;

        cyc(2);
        chk("rst_row", {28'b0, row}, 32'h0000000e);
        chk("rst_x", x, 0);
        chk("rst_key_code", {28'b0, key_code}, 0);
        chk("rst_key_valid", {31'b0, key_valid}, 0);
        chk("rst_key_down", {31'b0, key_down}, 0);

        clr = 1'b0;
        cyc(6);
        chk("row_before_midrun_clr", {28'b0, row}, 32'h0000000d);
        clr = 1'b1;
        #1;
        chk("async_clr_row", {28'b0, row}, 32'h0000000e);
        chk("async_clr_x", x, 0);
        chk("async_clr_kv", {31'b0, key_valid}, 0);
        chk("async_clr_kd", {31'b0, key_down}, 0);
        cyc(3);
        clr = 1'b0;
        cyc(2);
        chk("row_step0", {28'b0, row}, 32'h0000000e);
        cyc(4);
        chk("row_step1", {28'b0, row}, 32'h0000000d);
        cyc(4);
        chk("row_step2", {28'b0, row}, 32'h0000000b);
        cyc(4);
        chk("row_step3", {28'b0, row}, 32'h00000007);
        cyc(4);
        chk("row_step4", {28'b0, row}, 32'h0000000e);

        // Single press: row 2 / col 1
        press(4'h9);
        chk("single_x", x, 32'h00000009);

        // Bounce: row 1 / col 3 seen on two ticks, then released
        wait_row(4'b1101);
        keys[4'h7] = 1'b1;
        cyc(8);
        keys = '0;
        cyc(4);
        chk("bounce_row_resume1", {28'b0, row}, 32'h0000000b);
        cyc(4);
        chk("bounce_row_resume2", {28'b0, row}, 32'h00000007);
        chk("bounce_x", x, 32'h00000009);
        chk("bounce_kd", {31'b0, key_down}, 0);

        // Entry sequence with wrap of the oldest digits
        for (int k = 1; k <= 8; k++) press(4'(k));
        press(4'hf);
        chk("wrap_x", x, 32'h2345678f);

        // Simultaneous keys on row 0, then a second key on row 3 while held
        expect_key(4'h0);
        keys = '0;
        keys[4'h0] = 1'b1;
        keys[4'h2] = 1'b1;
        cyc(40);
        keys[4'hf] = 1'b1;
        cyc(40);
        chk("simul_key_down", {31'b0, key_down}, 1);
        keys = '0;
        cyc(28);
        chk("simul_x", x, 32'h345678f0);

        // Reset after two qualifying ticks, key stays held through clr
        wait_row(4'b1110);
        keys[4'h1] = 1'b1;
        cyc(8);
        clr = 1'b1;
        #1;
        chk("mid_deb_clr_x", x, 0);
        chk("mid_deb_clr_kv", {31'b0, key_valid}, 0);
        exp_x = '0;
        cyc(3);
        clr = 1'b0;
        expect_key(4'h1);
        cyc(40);
        chk("mid_deb_kd", {31'b0, key_down}, 1);
        keys = '0;
        cyc(28);
        chk("mid_deb_x", x, 32'h00000001);

        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
